// File: rtl/riscv_mem_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the data memory controller: data width, access size
// encodings and the controller FSM state type.
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering for the data memory.
//   size          : access size (byte/half/word/reserved)
//   load_unsigned : zero-extend sub-word loads when 1
//   offset        : address[1:0] of the access
//   wdata         : right-aligned store data
//   rword         : 32-bit word read from the array
//   byte_en       : per-lane write mask
//   wdata_lanes   : store data replicated onto every lane it may land in
//   rdata_ext     : selected and extended load data
//   misalign      : half with offset[0]=1 or word with offset!=0
// Misaligned offset bits are always dropped here; whether a misaligned access
// traps (MISALIGN_TRAP_EN) is decided by the top level.
// ---------------------------------------------------------------------------
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  size_t             size,
  input  logic              load_unsigned,
  input  logic [1:0]        offset,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rword,
  output logic [3:0]        byte_en,
  output logic [XLEN-1:0]   wdata_lanes,
  output logic [XLEN-1:0]   rdata_ext,
  output logic              misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rword[{offset, 3'b000} +: 8];
  assign lane_h = offset[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = '0;
    rdata_ext   = '0;
    misalign    = 1'b0;
    case (size)
      SIZE_BYTE: begin
        byte_en     = 4'b0001 << offset;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = load_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SIZE_HALF: begin
        misalign    = offset[0];
        byte_en     = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = load_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      SIZE_WORD: begin
        misalign    = |offset;
        byte_en     = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rword;
      end
      default: begin
        byte_en = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
// 32-bit data memory with valid/ready request and response channels,
// WAIT_STATES extra cycles of latency, byte/half/word stores and sign/zero
// extended loads. One request outstanding at a time.
//   clock, reset (async, active-high)
//   req_valid/req_ready, req_we, req_size, req_unsigned, req_address, req_wdata
//   resp_valid/resp_ready, resp_rdata, resp_error
// Build option: define MISALIGN_TRAP_EN to make misaligned half/word accesses
// fault instead of silently dropping the low address bits.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a request; inputs sampled here only
//   WAIT  | counting down wait states, request held in latch
//   RESP  | response presented, held until resp_ready
// ---------------------------------------------------------------------------
module data_memory_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_address,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [XLEN-1:0] mem [DEPTH];

  state_t          state;
  logic [3:0]      wait_cnt;

  logic            lat_we;
  size_t           lat_size;
  logic            lat_unsigned;
  logic [AW+1:0]   lat_addr;
  logic [XLEN-1:0] lat_wdata;

  // The commit edge may be the acceptance edge itself (WAIT_STATES = 0), so
  // the datapath looks at the live inputs in IDLE and the latch otherwise.
  logic            cur_we;
  size_t           cur_size;
  logic            cur_unsigned;
  logic [AW+1:0]   cur_addr;
  logic [XLEN-1:0] cur_wdata;
  logic [AW-1:0]   cur_idx;

  logic [3:0]      byte_en;
  logic [XLEN-1:0] wdata_lanes;
  logic [XLEN-1:0] rdata_ext;
  logic            misalign;
  logic            err_now;
  logic [XLEN-1:0] rdata_next;
  logic            enter_resp;
  logic            commit_wr;

  logic            unused_addr_hi;
  assign unused_addr_hi = ^req_address[XLEN-1:AW+2];

  assign req_ready = (state == IDLE);

  assign cur_we       = (state == IDLE) ? req_we               : lat_we;
  assign cur_size     = (state == IDLE) ? size_t'(req_size)    : lat_size;
  assign cur_unsigned = (state == IDLE) ? req_unsigned         : lat_unsigned;
  assign cur_addr     = (state == IDLE) ? req_address[AW+1:0]  : lat_addr;
  assign cur_wdata    = (state == IDLE) ? req_wdata            : lat_wdata;
  assign cur_idx      = cur_addr[AW+1:2];

  mem_lane_align u_align (
    .size          (cur_size),
    .load_unsigned (cur_unsigned),
    .offset        (cur_addr[1:0]),
    .wdata         (cur_wdata),
    .rword         (mem[cur_idx]),
    .byte_en       (byte_en),
    .wdata_lanes   (wdata_lanes),
    .rdata_ext     (rdata_ext),
    .misalign      (misalign)
  );

`ifdef MISALIGN_TRAP_EN
  assign err_now = (cur_size == SIZE_RSVD) || misalign;
`else
  assign err_now = (cur_size == SIZE_RSVD);
`endif

  assign rdata_next = (cur_we || err_now) ? '0 : rdata_ext;

  assign enter_resp = ((state == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                      ((state == WAIT) && (wait_cnt == 4'd0));
  assign commit_wr  = enter_resp && cur_we && !err_now && !reset;

  // Array has no reset: contents survive reset by design.
  always_ff @(posedge clock) begin
    if (commit_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[cur_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_error   <= 1'b0;
      lat_we       <= 1'b0;
      lat_size     <= SIZE_BYTE;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_size     <= size_t'(req_size);
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_address[AW+1:0];
            lat_wdata    <= req_wdata;
            if (WAIT_STATES == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rdata_next;
              resp_error <= err_now;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rdata_next;
            resp_error <= err_now;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ctrl
// Two instances share clock and reset: index 0 has no wait states, index 1
// has three. A byte-array model of each memory predicts every response.
// ---------------------------------------------------------------------------
module tb_data_memory_ctrl;

  localparam int DEPTH = 16;
  localparam int NB    = DEPTH * 4;
  localparam int WS0   = 0;
  localparam int WS1   = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_address  [2];
  logic [31:0] req_wdata    [2];
  logic        resp_valid   [2];
  logic        resp_ready   [2];
  logic [31:0] resp_rdata   [2];
  logic        resp_error   [2];

  logic [7:0]  mm [2][NB];
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  data_memory_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_address(req_address[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
  );

  data_memory_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_address(req_address[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory, wraps at NB bytes.
  task automatic model(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] exp_rd, output logic exp_err);
    int base, off, n;
    logic [31:0] v;
    base = int'(addr) & (NB - 4);
    off  = int'(addr[1:0]);
    exp_err = 1'b0;
    n = 0;
    case (sz)
      2'b00: n = 1;
      2'b01: begin
        n = 2;
`ifdef MISALIGN_TRAP_EN
        if (off % 2 != 0) exp_err = 1'b1;
`endif
        off = off - (off % 2);
      end
      2'b10: begin
        n = 4;
`ifdef MISALIGN_TRAP_EN
        if (off != 0) exp_err = 1'b1;
`endif
        off = 0;
      end
      default: exp_err = 1'b1;
    endcase
    exp_rd = 32'h0;
    if (!exp_err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mm[d][base + off + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mm[d][base + off + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        exp_rd = v;
      end
    end
  endtask

  task automatic txn(input int d, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input int hold,
                     output logic [31:0] got);
    logic [31:0] er, held;
    logic ee;
    int lat, ws;
    ws = (d == 0) ? WS0 : WS1;
    model(d, we, sz, uns, addr, wd, er, ee);
    @(negedge clock);
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_we[d] = we; req_size[d] = sz; req_unsigned[d] = uns;
    req_address[d] = addr; req_wdata[d] = wd; req_valid[d] = 1'b1;
    @(posedge clock);
    #1;
    req_valid[d] = 1'b0;
    req_we[d] = 1'($urandom); req_size[d] = 2'($urandom);
    req_address[d] = $urandom; req_wdata[d] = $urandom;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      if (!resp_valid[d]) chk("req_ready_wait", 32'(req_ready[d]), 32'd0);
    end while (!resp_valid[d] && lat < 40);
    chk("latency", 32'(lat), 32'(ws + 1));
    chk("rdata", resp_rdata[d], er);
    chk("error", 32'(resp_error[d]), 32'(ee));
    got = resp_rdata[d];
    held = resp_rdata[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("rdata_stable", resp_rdata[d], held);
      chk("valid_held", 32'(resp_valid[d]), 32'd1);
      chk("req_ready_resp", 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clock);
    #1;
    resp_ready[d] = 1'b0;
    @(negedge clock);
    chk("req_ready_after", 32'(req_ready[d]), 32'd1);
    chk("valid_clear", 32'(resp_valid[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] got, er;
    logic ee;
    int d;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = 2'b00;
      req_unsigned[k] = 1'b0; req_address[k] = 32'h0; req_wdata[k] = 32'h0;
      resp_ready[k] = 1'b0;
    end

    repeat (2) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[k], 32'd0);
      chk("rst_resp_error", 32'(resp_error[k]), 32'd0);
    end
    reset = 1'b0;

    // Give both arrays known contents.
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < DEPTH; w++)
        txn(k, 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, 0, got);

    // Directed sequence, zero wait states.
    txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, got);
    txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, got);
    chk("word_load_deadbeef", got, 32'hDEADBEEF);
    txn(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, 0, got);
    txn(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, got);
    chk("byte_signed", got, 32'hFFFF_FF80);
    txn(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, got);
    chk("byte_unsigned", got, 32'h0000_0080);
    txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, got);
    chk("word_after_byte", got, 32'h80ADBEEF);
    txn(0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1, got);
    txn(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h1234_5678, 0, got);
    txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, got);
    chk("rsvd_no_write", got, 32'h80ADBEEF);
    txn(0, 1'b0, 2'b10, 1'b0, 32'h10 + 32'(NB), 32'h0, 0, got);
    chk("addr_wrap", got, 32'h80ADBEEF);

    // Three wait states, response held for five cycles.
    txn(1, 1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFE_F00D, 5, got);
    txn(1, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 5, got);
    chk("ws3_half_hi", got, 32'hFFFF_CAFE);

    // Reset during WAIT of a store: store discarded.
    model(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, er, ee);
    @(negedge clock);
    req_we[1] = 1'b1; req_size[1] = 2'b10; req_unsigned[1] = 1'b0;
    req_address[1] = 32'h20; req_wdata[1] = ~er; req_valid[1] = 1'b1;
    @(posedge clock);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clock);
    chk("wait_req_ready", 32'(req_ready[1]), 32'd0);
    reset = 1'b1;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid[1]), 32'd0);
    chk("midrst_req_ready", 32'(req_ready[1]), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    txn(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, got);
    chk("store_discarded", got, er);

    // Randomized traffic on both instances.
    for (int t = 0; t < 80; t++) begin
      d = int'($urandom_range(0, 1));
      txn(d, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
          int'($urandom_range(0, 3)), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised 32-bit RISC-V data memory with a valid/ready request and response handshake, configurable wait states, byte/half/word stores, and sign- or zero-extended loads.
- Sits behind the core's load/store unit and replaces the single-cycle word-only array.
- Handles one outstanding request at a time, sequenced by a small FSM.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two ≥ 2.
- WAIT_STATES, 0, extra cycles between request acceptance and response; range 0..15.

Ports:
- clock  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  load zero-extends when 1; ignored for stores.
- req_address  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  access faulted.

Behaviour:
- Clocking and reset: `clock` is the only clock. `reset` is asynchronous and active-high.
- Reset state:
  - state = IDLE, resp_valid = 0, resp_rdata = 0, resp_error = 0.
  - req_ready is decoded from state, so it is 1 in IDLE, including while reset is held.
  - The array itself is not reset; its contents are retained across reset.
- Word index: req_address[log2(DEPTH)+1:2]. Upper bits are ignored, so accesses wrap modulo DEPTH words.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. When req_valid = 1, latch we/size/unsigned/address/wdata. Go to WAIT if WAIT_STATES > 0, otherwise go to RESP.
  - WAIT: req_ready = 0. A counter loads WAIT_STATES-1 on entry and decrements each cycle. At 0, go to RESP.
  - RESP: resp_valid = 1. resp_rdata and resp_error are held stable until resp_ready = 1, then go to IDLE. No request is accepted in the same cycle; req_ready goes to 1 the cycle after the handshake.
- Latency: request accepted at edge E → resp_valid high after edge E+1+WAIT_STATES-1. That is the cycle right after E when WAIT_STATES = 0.
- Commit point: the store write and the load read both happen on the clock edge that enters RESP.
  - Reads return the array value at that edge.
  - A reset before that edge discards the pending store; the array is unchanged.
- Store lanes:
  - byte: writes lane address[1:0] with wdata[7:0].
  - half: writes lanes {address[1],0} and {address[1],1} with wdata[15:0].
  - word: writes all four lanes.
  - Unselected lanes are untouched.
- Load extraction:
  - Select the byte/half per the lane rules above.
  - Sign-extend from bit 7 or 15 unless req_unsigned = 1, in which case zero-extend.
  - A word load returns the full word; req_unsigned has no effect.
- Store responses: resp_rdata = 0.
- Reserved size 11: resp_error = 1, no write, resp_rdata = 0.
- Reset mid-operation: any state returns to IDLE immediately and an in-flight response is dropped.
- Inputs are only sampled in IDLE. Changing them during WAIT or RESP has no effect.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A half access with address[0] = 1, or a word access with address[1:0] ≠ 00, is misaligned.
  - Misaligned accesses respond with resp_error = 1, perform no write, and return resp_rdata = 0.
  - Latency is unchanged.
- Undefined:
  - Misaligned offset bits are forced to zero: half ignores address[0]; word ignores address[1:0].
  - The access completes normally with resp_error = 0.
- Reserved size errors apply in both builds.

Decomposition:
- Package riscv_mem_pkg holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD;
  - FSM state typedef (IDLE/WAIT/RESP);
  - XLEN = 32.
- Sub-module mem_lane_align (combinational): takes size, unsigned, offset, wdata and the read word; produces the 4-bit byte-write mask, lane-replicated write data, extended load data, and the misalign flag.
- The top level owns the FSM, wait counter, request latch, array, and response registers.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then word load 0x10 with WAIT_STATES = 0 → resp_valid the cycle after acceptance, rdata 0xDEADBEEF, error 0.
- Byte store 0x80 to 0x13; load byte signed 0x13 → 0xFFFFFF80; load byte unsigned → 0x00000080; word load 0x10 → 0x80ADBEEF.
- WAIT_STATES = 3, resp_ready held 0 for 5 cycles → resp_valid after 4 cycles, rdata stable, req_ready 0 throughout; resp_ready = 1 → IDLE, req_ready 1 on the next cycle.
- Half load 0x11:
  - MISALIGN_TRAP_EN defined → error 1, rdata 0.
  - Undefined → data from 0x10 (0xFFFFBEEF signed), error 0.
- size = 11 store to 0x10 → error 1; later word load 0x10 unchanged.
- Assert reset during WAIT of a store to 0x20 → resp_valid 0, state IDLE; load 0x20 returns the prior content.
